jk_reg_bank: RTL and testbench
==============================

// Module: jk_reg_bank
// PURPOSE
//  Parametrised multi-bit JK register bank: WIDTH independent flip-flops sharing one clock,
//  with run-time mode select (JK / T / D / SR), synchronous parallel load and set,
//  per-bit change flags, a saturating bit-change counter and a sticky SR-illegal flag.
//  Drop-in state element for control/status logic that needs per-bit J/K semantics.
// PARAMETERS
//  WIDTH    8      number of flip-flops (>=1)
//  RST_VAL  0      WIDTH-bit value loaded into q on rst
//  CNT_W    16     width of chg_cnt; counter saturates at 2^CNT_W-1
// PORTS
//  clk        in   1        clock; all state updates on rising edge
//  rst        in   1        synchronous reset, active-high
//  set        in   1        synchronous set, active-high: q <= all ones
//  en         in   1        mode-update enable; 0 = hold (load/set/rst still act)
//  mode       in   2        00 JK, 01 T, 10 D, 11 SR
//  j          in   WIDTH    per-bit J / T / D / S input (by mode)
//  k          in   WIDTH    per-bit K / - / - / R input (by mode)
//  load       in   1        parallel load strobe
//  load_data  in   WIDTH    value written on load
//  err_clr    in   1        clears sr_err
//  q          out  WIDTH    register state
//  qb         out  WIDTH    ~q, combinational
//  chg        out  WIDTH    registered: bits of q that changed on the last edge
//  chg_cnt    out  CNT_W    saturating total of changed bits since reset
//  sr_err     out  1        sticky: SR mode saw S=R=1 on some bit while enabled
// BEHAVIOUR
//  - Reset values: q=RST_VAL, qb=~RST_VAL, chg=0, chg_cnt=0, sr_err=0.
//  - Priority per edge: rst > set > load > (en & mode update) > hold.
//  - Latency: q reflects inputs on the edge they are sampled; chg/chg_cnt reflect
//    that same edge (computed from q_next ^ q, registered with q).
//  - Per bit i, when en=1 and no higher-priority action:
//    JK: 00 hold, 01 ->0, 10 ->1, 11 toggle.   T: j[i]=1 toggle, else hold; k ignored.
//    D: q[i] <= j[i]; k ignored.   SR: 10 ->1, 01 ->0, 00 hold, 11 hold + sr_err.
//  - sr_err: set when en=1, mode=11, no rst/set/load, and any bit has j&k=1.
//    Cleared by rst or err_clr; simultaneous err_clr and new illegal -> stays 1 (set wins).
//  - set and load: chg = q_next ^ q as normal; counted in chg_cnt.
//  - rst: chg forced 0, chg_cnt forced 0 (reset changes are not counted).
//  - chg_cnt += popcount(chg_next); saturating add, never wraps; holds at max.
//  - mode change takes effect on the same edge it is sampled; no internal mode state.
//  - en=0: q, sr_err hold; chg=0 unless load/set acts.
// TESTING
//  1 rst=1 one cycle, WIDTH=8, RST_VAL=8'hA5 -> q=A5, qb=5A, chg=0, chg_cnt=0, sr_err=0.
//  2 mode=00, j=F0, k=0F, en=1 from q=A5 -> q=F0, chg=55, chg_cnt=4; next j=k=FF -> q=0F, chg=FF, cnt=12.
//  3 mode=01, j=01 for 3 edges from q=00 -> q toggles 01,00,01; chg=01 each edge; cnt+=3.
//  4 mode=11, j=k=03 -> q holds, sr_err=1; err_clr with j=k=00 -> sr_err=0; err_clr with j=k=01 -> sr_err stays 1.
//  5 same edge rst=1,set=1,load=1 -> q=RST_VAL; set=1,load=1 -> q=FF; load only, en=1 -> q=load_data.
//  6 CNT_W=4, D mode alternating j=FF/00 -> chg_cnt saturates at 15 and holds; rst -> 0.

Source files
------------

// File: rtl/jk_reg_bank.sv
// jk_reg_bank: WIDTH independent J/K-style flip-flops with run-time mode select
// (JK / T / D / SR), synchronous set/load, per-bit change flags, a saturating
// changed-bit counter and a sticky SR-illegal flag.
module jk_reg_bank #(
  parameter int unsigned            WIDTH   = 8,
  parameter logic [WIDTH-1:0]       RST_VAL = '0,
  parameter int unsigned            CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             err_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic [WIDTH-1:0] chg,
  output logic [CNT_W-1:0] chg_cnt,
  output logic             sr_err
);

  localparam int unsigned PC_W  = $clog2(WIDTH + 1);
  localparam int unsigned SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;

  localparam logic [1:0] MODE_JK = 2'b00;
  localparam logic [1:0] MODE_T  = 2'b01;
  localparam logic [1:0] MODE_D  = 2'b10;
  localparam logic [1:0] MODE_SR = 2'b11;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] q_mode;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] chg_next;
  logic [PC_W-1:0]  pop;
  logic [SUM_W-1:0] sum;
  logic [CNT_W-1:0] cnt_next;
  logic             illegal;
  logic             err_next;

  // Per-bit next state for the selected mode, ignoring set/load
  always_comb begin
    q_mode = q;
    case (mode)
      MODE_JK: q_mode = (j & ~q) | (~k & q);
      MODE_T:  q_mode = q ^ j;
      MODE_D:  q_mode = j;
      MODE_SR: q_mode = (j & ~k) | (q & ~(j ^ k));
    endcase
  end

  // Priority resolution (set > load > enabled mode update > hold), change
  // flags, popcount and saturating counter update
  always_comb begin
    q_next = q;
    if (set)       q_next = '1;
    else if (load) q_next = load_data;
    else if (en)   q_next = q_mode;

    chg_next = q_next ^ q;

    pop = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      pop = pop + PC_W'(chg_next[i]);
    end

    sum      = SUM_W'(chg_cnt) + SUM_W'(pop);
    cnt_next = (sum > SUM_W'(CNT_MAX)) ? CNT_MAX : CNT_W'(sum);

    illegal  = en && (mode == MODE_SR) && !set && !load && (|(j & k));
    err_next = sr_err;
    if (illegal)      err_next = 1'b1;
    else if (err_clr) err_next = 1'b0;
  end

  // State register; reset changes are neither flagged nor counted
  always_ff @(posedge clk) begin
    if (rst) begin
      q       <= RST_VAL;
      chg     <= '0;
      chg_cnt <= '0;
      sr_err  <= 1'b0;
    end else begin
      q       <= q_next;
      chg     <= chg_next;
      chg_cnt <= cnt_next;
      sr_err  <= err_next;
    end
  end

  assign qb = ~q;

endmodule

// File: tb/tb_jk_reg_bank.sv
// Directed bench for jk_reg_bank: a CNT_W=16 instance for function checks and
// a CNT_W=4 instance sharing the same stimulus for counter saturation.
module tb_jk_reg_bank;

  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst, set, en, load, err_clr;
  logic [1:0]       mode;
  logic [WIDTH-1:0] j, k, load_data;
  logic [WIDTH-1:0] q, qb, chg;
  logic [15:0]      chg_cnt;
  logic             sr_err;
  logic [WIDTH-1:0] q4, qb4, chg4;
  logic [3:0]       chg_cnt4;
  logic             sr_err4;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  always #5 clk = ~clk;

  jk_reg_bank #(.WIDTH(WIDTH), .RST_VAL(8'hA5), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .set(set), .en(en), .mode(mode), .j(j), .k(k),
    .load(load), .load_data(load_data), .err_clr(err_clr),
    .q(q), .qb(qb), .chg(chg), .chg_cnt(chg_cnt), .sr_err(sr_err)
  );

  jk_reg_bank #(.WIDTH(WIDTH), .RST_VAL(8'hA5), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .set(set), .en(en), .mode(mode), .j(j), .k(k),
    .load(load), .load_data(load_data), .err_clr(err_clr),
    .q(q4), .qb(qb4), .chg(chg4), .chg_cnt(chg_cnt4), .sr_err(sr_err4)
  );

  // Count one comparison and report it on mismatch
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Advance one rising edge and settle just after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; set = 0; en = 0; load = 0; err_clr = 0;
    mode = 2'b00; j = '0; k = '0; load_data = '0;
  endtask

  task automatic chk_state(input string tag, input logic [7:0] eq, input logic [7:0] ec,
                           input logic [15:0] ecnt, input logic eerr);
    check({tag, ".q"},      32'(q),       32'(eq));
    check({tag, ".chg"},    32'(chg),     32'(ec));
    check({tag, ".chg_cnt"},32'(chg_cnt), 32'(ecnt));
    check({tag, ".sr_err"}, 32'(sr_err),  32'(eerr));
  endtask

  initial begin
    idle();
    #2;

    // 1: reset
    rst = 1; step(); rst = 0;
    chk_state("rst", 8'hA5, 8'h00, 16'd0, 1'b0);
    check("rst.qb", 32'(qb), 32'h5A);
    check("rst.cnt4", 32'(chg_cnt4), 32'd0);

    // 2: JK set/reset then toggle
    en = 1; mode = 2'b00; j = 8'hF0; k = 8'h0F; step();
    chk_state("jk_sr", 8'hF0, 8'h55, 16'd4, 1'b0);
    j = 8'hFF; k = 8'hFF; step();
    chk_state("jk_tog", 8'h0F, 8'hFF, 16'd12, 1'b0);
    check("jk_tog.qb", 32'(qb), 32'hF0);
    j = 8'h00; k = 8'h00; step();
    chk_state("jk_hold", 8'h0F, 8'h00, 16'd12, 1'b0);

    // 3: load 00, then T mode toggle of bit 0
    load = 1; load_data = 8'h00; step(); load = 0;
    chk_state("ld0", 8'h00, 8'h0F, 16'd16, 1'b0);
    mode = 2'b01; j = 8'h01; k = 8'hFF; step();
    chk_state("t1", 8'h01, 8'h01, 16'd17, 1'b0);
    step();
    chk_state("t2", 8'h00, 8'h01, 16'd18, 1'b0);
    step();
    chk_state("t3", 8'h01, 8'h01, 16'd19, 1'b0);

    // 4: SR illegal, sticky flag and clear precedence
    mode = 2'b11; j = 8'h03; k = 8'h03; step();
    chk_state("sr_ill", 8'h01, 8'h00, 16'd19, 1'b1);
    j = 8'h00; k = 8'h00; err_clr = 1; step();
    chk_state("sr_clr", 8'h01, 8'h00, 16'd19, 1'b0);
    j = 8'h01; k = 8'h01; step();
    chk_state("sr_clr_set", 8'h01, 8'h00, 16'd19, 1'b1);
    err_clr = 0; j = 8'h80; k = 8'h01; step();
    chk_state("sr_sr", 8'h80, 8'h81, 16'd21, 1'b1);
    en = 0; mode = 2'b10; j = 8'hFF; step();
    chk_state("en0", 8'h80, 8'h00, 16'd21, 1'b1);

    // 5: priority rst > set > load > mode
    rst = 1; set = 1; load = 1; load_data = 8'h3C; step(); rst = 0;
    chk_state("pri_rst", 8'hA5, 8'h00, 16'd0, 1'b0);
    step(); set = 0;
    chk_state("pri_set", 8'hFF, 8'h5A, 16'd4, 1'b0);
    en = 1; mode = 2'b10; j = 8'h00; step(); load = 0;
    chk_state("pri_load", 8'h3C, 8'hC3, 16'd8, 1'b0);

    // 6: D mode alternating; 4-bit counter saturates
    rst = 1; step(); rst = 0;
    check("sat_rst.cnt4", 32'(chg_cnt4), 32'd0);
    mode = 2'b10; en = 1;
    j = 8'hFF; step();
    check("sat1.cnt4", 32'(chg_cnt4), 32'd4);
    check("sat1.q", 32'(q4), 32'hFF);
    j = 8'h00; step();
    check("sat2.cnt4", 32'(chg_cnt4), 32'd12);
    j = 8'hFF; step();
    check("sat3.cnt4", 32'(chg_cnt4), 32'd15);
    check("sat3.cnt16", 32'(chg_cnt), 32'd20);
    j = 8'h00; step();
    check("sat4.cnt4", 32'(chg_cnt4), 32'd15);
    check("sat4.cnt16", 32'(chg_cnt), 32'd28);
    rst = 1; step(); rst = 0;
    check("sat_clr.cnt4", 32'(chg_cnt4), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
